expr_fsm: RTL and testbench
===========================

// Module: expr_fsm
// PURPOSE
//  Streaming ASCII arithmetic-expression recogniser and evaluator.
//  - Consumes one character per accepted beat.
//  - Flags whether the prefix received so far is a complete legal expression: digit-run (op digit-run)*.
//  - Reports the value of that prefix with standard precedence ('*' binds tighter than '+').
//  - Successor of the single-digit recogniser: adds multi-digit operands, an input valid strobe,
//    sticky error reporting and a configurable-width result.
// PARAMETERS
//  MAX_DIGITS  3   max digits per operand; a longer run is an error
//  VAL_W       16  result width; all arithmetic is modulo 2^VAL_W
// PORTS
//  clk     in   1      single clock, rising edge
//  clr     in   1      synchronous, active-high reset; has priority over in_vld
//  in_vld  in   1      in is consumed on this edge only when 1
//  in      in   8      ASCII character
//  out     out  1      1 = accepted prefix is a complete legal expression
//  err     out  1      1 = illegal prefix seen; sticky until clr
//  value   out  VAL_W  value of the accepted prefix
// BEHAVIOUR
//  - Reset (clr=1 at edge): state=EMPTY; out=0, err=0, value=0; sum=0, prod=1, cur=0, ndig=0.
//  - All outputs are registered. A char sampled at edge k is reflected after edge k (latency 1).
//  - in_vld=0: every register holds.
//  - Character classes:
//    - digit: '0'..'9' (48..57), d = in-48
//    - op: '+' (43) and '*' (42)
//    - anything else: illegal
//  - States:
//    - EMPTY: digit->NUM; op or illegal->ERR
//    - NUM:
//      - digit with ndig<MAX_DIGITS -> NUM
//      - digit with ndig==MAX_DIGITS -> ERR
//      - op -> OPND
//      - illegal -> ERR
//    - OPND (operator just seen): digit->NUM; op or illegal->ERR
//    - ERR: absorbing; only clr leaves it
//  - Datapath updates (VAL_W-bit wrap):
//    - digit: cur<=cur*10+d, ndig<=ndig+1
//    - '*': prod<=prod*cur, cur<=0, ndig<=0
//    - '+': sum<=sum+prod*cur, prod<=1, cur<=0, ndig<=0
//  - value <= next_sum + next_prod*next_cur.
//    - In OPND, value is the prefix without its trailing operator. Example: "2*3+" gives 6.
//  - out=1 exactly in NUM.
//  - Entering ERR: err<=1, out<=0, value<=0; all three hold until clr.
//  - A leading zero is legal: "007" = 7.
//  - clr together with in_vld=1: reset wins and the char is dropped.
// CONFIGURATION
//  - EXPR_SUB_EN defined:
//    - '-' (45) is an operator with '+' precedence.
//    - Adds sign register sgn (reset +1).
//    - On '+'/'-': sum<=sum+sgn*prod*cur; sgn<=+1 for '+', -1 for '-'.
//    - value = sum + sgn*prod*cur, two's complement wrap.
//  - EXPR_SUB_EN undefined: '-' is illegal (->ERR); no sgn register.
// STRUCTURE
//  - Package expr_pkg:
//    - state typedef {EMPTY, NUM, OPND, ERR}
//    - ASCII constants CH_0, CH_9, CH_PLUS, CH_MUL, CH_MINUS
//  - Sub-module expr_classify (combinational): in -> is_digit, is_op, op_kind, digit[3:0].
//    Used by expr_fsm for next-state and datapath decode.
// TESTING
//  1. clr, then 50,42,51,43,56 ("2*3+8"), vld each cycle -> out 1,0,1,0,1; value 2,2,6,6,14; err 0
//  2. "2*3+89" -> value 95, out=1; then '*','+' -> err=1 after '+', value 0; stays err while feeding digits
//  3. "2*" then clr=1 with in_vld=1 -> out 0, err 0, value 0; then "+" -> err=1
//  4. '1' vld=1; in=43 vld=0; '2' vld=1 -> value 12, out 1 (gap char ignored)
//  5. MAX_DIGITS=3: "123" out=1 value 123; '4' -> err=1. VAL_W=8: "200*2" -> value 144
//  6. EXPR_SUB_EN: "9-2*3" -> value 3 (16'h0003); "1-5" -> 16'hFFFC. Without the macro: "9-" -> err=1

Source files
------------

// File: rtl/expr_pkg.sv
// -----------------------------------------------------------------------------
// expr_pkg
// Shared types and constants for the streaming expression recogniser.
//   state_e : recogniser state (EMPTY, NUM, OPND, ERR)
//   op_e    : decoded operator kind
//   CH_*    : ASCII codes of the characters the recogniser understands
// Optional feature macro: EXPR_SUB_EN (enables '-' as an operator).
// -----------------------------------------------------------------------------
package expr_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing accepted since clr
    NUM   = 2'd1,  // inside an operand; prefix is a complete expression
    OPND  = 2'd2,  // operator just accepted; an operand must follow
    ERR   = 2'd3   // illegal prefix seen; absorbing until clr
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_SUB = 2'd2
  } op_e;

  localparam logic [7:0] CH_0     = 8'd48;
  localparam logic [7:0] CH_9     = 8'd57;
  localparam logic [7:0] CH_PLUS  = 8'd43;
  localparam logic [7:0] CH_MUL   = 8'd42;
  localparam logic [7:0] CH_MINUS = 8'd45;

endpackage

// File: rtl/expr_classify.sv
// -----------------------------------------------------------------------------
// expr_classify
// Combinational character-class decoder for expr_fsm.
// Ports:
//   in_i        [7:0] ASCII character
//   is_digit_o        1 = '0'..'9'
//   is_op_o           1 = recognised operator
//   op_kind_o         which operator (valid when is_op_o)
//   digit_o     [3:0] numeric digit value (valid when is_digit_o)
// Optional feature macro: EXPR_SUB_EN -- when defined '-' is an operator,
// otherwise it is classified as illegal.
// -----------------------------------------------------------------------------
module expr_classify
  import expr_pkg::*;
(
  input  logic [7:0] in_i,
  output logic       is_digit_o,
  output logic       is_op_o,
  output op_e        op_kind_o,
  output logic [3:0] digit_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    is_digit_o = (in_i >= CH_0) && (in_i <= CH_9);
    is_op_o    = 1'b0;
    op_kind_o  = OP_ADD;
    // '0' is 0x30, so the low nibble of a digit character is its value.
    digit_o    = in_i[3:0];

    case (in_i)
      CH_PLUS: begin
        is_op_o   = 1'b1;
        op_kind_o = OP_ADD;
      end
      CH_MUL: begin
        is_op_o   = 1'b1;
        op_kind_o = OP_MUL;
      end
`ifdef EXPR_SUB_EN
      CH_MINUS: begin
        is_op_o   = 1'b1;
        op_kind_o = OP_SUB;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/expr_fsm.sv
// -----------------------------------------------------------------------------
// expr_fsm
// Streaming ASCII arithmetic-expression recogniser and evaluator. Accepts one
// character per in_vld beat and reports, one cycle later, whether the accepted
// prefix is a complete expression  digits (op digits)*  and its value with
// '*' binding tighter than '+'. Arithmetic wraps modulo 2^VAL_W.
// Parameters:
//   MAX_DIGITS  max digits per operand; a longer run is an error
//   VAL_W       result width
// Ports:
//   clk          rising-edge clock
//   clr          synchronous active-high reset; wins over in_vld
//   in_vld       in is consumed on this edge only when 1
//   in     [7:0] ASCII character
//   out          1 = accepted prefix is a complete legal expression
//   err          1 = illegal prefix seen; sticky until clr
//   value        value of the accepted prefix (0 once in error)
// Optional feature macro: EXPR_SUB_EN -- adds '-' at '+' precedence with a
// sign register; value becomes a two's-complement wrapped result.
// -----------------------------------------------------------------------------
module expr_fsm
  import expr_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int VAL_W      = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic [VAL_W-1:0] value
);

  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);

  logic       is_digit;
  logic       is_op;
  op_e        op_kind;
  logic [3:0] digit;

  expr_classify u_classify (
    .in_i       (in),
    .is_digit_o (is_digit),
    .is_op_o    (is_op),
    .op_kind_o  (op_kind),
    .digit_o    (digit)
  );

  // Expression value is tracked as sum + prod*cur: sum holds completed
  // '+'-separated terms, prod the product of the current term so far and
  // cur the operand being typed.
  state_e              state_q, state_d;
  logic [VAL_W-1:0]    sum_q,   sum_d;
  logic [VAL_W-1:0]    prod_q,  prod_d;
  logic [VAL_W-1:0]    cur_q,   cur_d;
  logic [NDIG_W-1:0]   ndig_q,  ndig_d;
  logic                out_q,   out_d;
  logic                err_q,   err_d;
  logic [VAL_W-1:0]    value_q, value_d;
`ifdef EXPR_SUB_EN
  logic                sgn_q,   sgn_d;    // 1 = current term is subtracted
`endif

  logic take_digit;
  logic take_op;
  logic go_err;

  // Next-state decode: exactly one of take_digit / take_op / go_err fires
  // on an accepted character outside ERR.
  always_comb begin
    take_digit = 1'b0;
    take_op    = 1'b0;
    go_err     = 1'b0;
    if (in_vld) begin
      case (state_q)
        EMPTY, OPND: begin
          if (is_digit) take_digit = 1'b1;
          else          go_err     = 1'b1;
        end
        NUM: begin
          if (is_digit) begin
            if (ndig_q == NDIG_W'(MAX_DIGITS)) go_err     = 1'b1;
            else                               take_digit = 1'b1;
          end else if (is_op) begin
            take_op = 1'b1;
          end else begin
            go_err = 1'b1;
          end
        end
        default: ;  // ERR absorbs everything
      endcase
    end
  end

  // Datapath next values.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    cur_d   = cur_q;
    ndig_d  = ndig_q;
    out_d   = out_q;
    err_d   = err_q;
    value_d = value_q;
`ifdef EXPR_SUB_EN
    sgn_d   = sgn_q;
`endif

    if (take_digit) begin
      state_d = NUM;
      cur_d   = cur_q * VAL_W'(10) + VAL_W'(digit);
      ndig_d  = ndig_q + 1'b1;
      out_d   = 1'b1;
`ifdef EXPR_SUB_EN
      value_d = sgn_q ? (sum_q - prod_q * cur_d) : (sum_q + prod_q * cur_d);
`else
      value_d = sum_q + prod_q * cur_d;
`endif
    end else if (take_op) begin
      state_d = OPND;
      cur_d   = '0;
      ndig_d  = '0;
      out_d   = 1'b0;
      // value_d holds: an operator does not change the value of the prefix
      // it terminates ("2*" still reports 2), which sum+prod*cur with cur=0
      // would not give for '*'.
      if (op_kind == OP_MUL) begin
        prod_d = prod_q * cur_q;
      end else begin
`ifdef EXPR_SUB_EN
        sum_d = sgn_q ? (sum_q - prod_q * cur_q) : (sum_q + prod_q * cur_q);
        sgn_d = (op_kind == OP_SUB);
`else
        sum_d = sum_q + prod_q * cur_q;
`endif
        prod_d = VAL_W'(1);
      end
    end else if (go_err) begin
      state_d = ERR;
      err_d   = 1'b1;
      out_d   = 1'b0;
      value_d = '0;
    end
  end

  // Single state/output register; outputs are registered copies.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (clr) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      prod_q  <= VAL_W'(1);
      cur_q   <= '0;
      ndig_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
      value_q <= '0;
`ifdef EXPR_SUB_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      cur_q   <= cur_d;
      ndig_q  <= ndig_d;
      out_q   <= out_d;
      err_q   <= err_d;
      value_q <= value_d;
`ifdef EXPR_SUB_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign out   = out_q;
  assign err   = err_q;
  assign value = value_q;

endmodule

// File: tb/tb_expr_fsm.sv
// -----------------------------------------------------------------------------
// tb_expr_fsm
// Drives two expr_fsm instances (VAL_W=16 and VAL_W=8) with the same character
// stream and compares them against a reference model that keeps the accepted
// prefix as a character queue and re-evaluates it from scratch each beat.
// Honours EXPR_SUB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_expr_fsm;

  localparam int MAXD = 3;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        in_vld = 1'b0;
  logic [7:0]  in = 8'd0;
  logic        out16, err16, out8, err8;
  logic [15:0] value16;
  logic [7:0]  value8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  expr_fsm #(.MAX_DIGITS(MAXD), .VAL_W(16)) dut (
    .clk(clk), .clr(clr), .in_vld(in_vld), .in(in),
    .out(out16), .err(err16), .value(value16)
  );

  expr_fsm #(.MAX_DIGITS(MAXD), .VAL_W(8)) dut8 (
    .clk(clk), .clr(clr), .in_vld(in_vld), .in(in),
    .out(out8), .err(err8), .value(value8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned pre[$];   // accepted legal prefix
  bit           m_err;

  function automatic bit is_dig(byte unsigned c);
    return (c >= 8'd48) && (c <= 8'd57);
  endfunction

  function automatic bit is_opc(byte unsigned c);
`ifdef EXPR_SUB_EN
    return (c == 8'd43) || (c == 8'd42) || (c == 8'd45);
`else
    return (c == 8'd43) || (c == 8'd42);
`endif
  endfunction

  // Value of the prefix (trailing operator ignored), modulo 2^w.
  function automatic longint eval_prefix(int w);
    longint      mask = (longint'(1) << w) - 1;
    longint      nums[$];
    byte unsigned ops[$];
    longint      num = 0;
    longint      total = 0;
    longint      term;
    bit          neg = 0;
    if (pre.size() == 0) return 0;
    foreach (pre[i]) begin
      if (is_dig(pre[i])) num = num * 10 + longint'(pre[i] - 8'd48);
      else begin
        nums.push_back(num);
        ops.push_back(pre[i]);
        num = 0;
      end
    end
    if (is_dig(pre[pre.size()-1])) nums.push_back(num);
    else void'(ops.pop_back());
    term = nums[0] & mask;
    for (int j = 0; j < ops.size(); j++) begin
      if (ops[j] == 8'd42) term = (term * (nums[j+1] & mask)) & mask;
      else begin
        total = neg ? total - term : total + term;
        neg   = (ops[j] == 8'd45);
        term  = nums[j+1] & mask;
      end
    end
    total = neg ? total - term : total + term;
    return total & mask;
  endfunction

  function automatic void model_update(bit c_clr, bit c_vld, byte unsigned c);
    int run = 0;
    if (c_clr) begin
      pre.delete();
      m_err = 1'b0;
      return;
    end
    if (!c_vld || m_err) return;
    for (int i = pre.size() - 1; i >= 0; i--) begin
      if (!is_dig(pre[i])) break;
      run++;
    end
    if (is_dig(c)) begin
      if (run >= MAXD) m_err = 1'b1;
      else pre.push_back(c);
    end else if (is_opc(c)) begin
      if (pre.size() == 0 || !is_dig(pre[pre.size()-1])) m_err = 1'b1;
      else pre.push_back(c);
    end else begin
      m_err = 1'b1;
    end
  endfunction

  // One clock beat: drive on negedge, update model at posedge, sample #1 later.
  task automatic step(input bit c_clr, input bit c_vld, input byte unsigned c);
    bit     e_out;
    longint e16, e8;
    @(negedge clk);
    clr = c_clr;
    in_vld = c_vld;
    in = c;
    @(posedge clk);
    model_update(c_clr, c_vld, c);
    #1;
    e_out = !m_err && (pre.size() > 0) && is_dig(pre[pre.size()-1]);
    e16   = m_err ? 0 : eval_prefix(16);
    e8    = m_err ? 0 : eval_prefix(8);
    check("out",    32'(out16),   32'(e_out));
    check("err",    32'(err16),   32'(m_err));
    check("value",  32'(value16), 32'(e16));
    check("out8",   32'(out8),    32'(e_out));
    check("err8",   32'(err8),    32'(m_err));
    check("value8", 32'(value8),  32'(e8));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i]);
  endtask

  task automatic do_clr();
    step(1'b1, 1'b0, 8'd0);
  endtask

  byte unsigned t1_ch[5] = '{8'd50, 8'd42, 8'd51, 8'd43, 8'd56};
  int           t1_v[5]  = '{2, 2, 6, 6, 14};
  bit           t1_o[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  byte unsigned junk[5]  = '{8'd32, 8'd97, 8'd47, 8'd45, 8'd61};
  byte unsigned opsl[3]  = '{8'd43, 8'd42, 8'd45};

  initial begin
    m_err = 1'b0;

    // Reset state
    do_clr();
    check("rst_out", 32'(out16), 32'd0);
    check("rst_err", 32'(err16), 32'd0);
    check("rst_val", 32'(value16), 32'd0);

    // 1: "2*3+8"
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, t1_ch[i]);
      check("t1_out", 32'(out16), 32'(t1_o[i]));
      check("t1_val", 32'(value16), 32'(t1_v[i]));
      check("t1_err", 32'(err16), 32'd0);
    end

    // 2: multi-digit operand, then double operator -> sticky error
    do_clr();
    send_str("2*3+89");
    check("t2_val", 32'(value16), 32'd95);
    check("t2_out", 32'(out16), 32'd1);
    send_str("*+");
    check("t2_err", 32'(err16), 32'd1);
    check("t2_errval", 32'(value16), 32'd0);
    send_str("123");
    check("t2_sticky", 32'(err16), 32'd1);
    check("t2_stickyout", 32'(out16), 32'd0);

    // 3: clr beats a valid char
    do_clr();
    send_str("2*");
    step(1'b1, 1'b1, 8'd43);
    check("t3_out", 32'(out16), 32'd0);
    check("t3_err", 32'(err16), 32'd0);
    check("t3_val", 32'(value16), 32'd0);
    send_str("+");
    check("t3_lead_op", 32'(err16), 32'd1);

    // 4: in_vld=0 gap char ignored
    do_clr();
    step(1'b0, 1'b1, 8'd49);
    step(1'b0, 1'b0, 8'd43);
    step(1'b0, 1'b1, 8'd50);
    check("t4_val", 32'(value16), 32'd12);
    check("t4_out", 32'(out16), 32'd1);

    // 5: digit limit and 8-bit wrap; leading zero
    do_clr();
    send_str("123");
    check("t5_val", 32'(value16), 32'd123);
    check("t5_out", 32'(out16), 32'd1);
    send_str("4");
    check("t5_err", 32'(err16), 32'd1);
    do_clr();
    send_str("200*2");
    check("t5_wrap8", 32'(value8), 32'd144);
    check("t5_full16", 32'(value16), 32'd400);
    do_clr();
    send_str("007");
    check("t5_lead0", 32'(value16), 32'd7);

    // 6: subtraction feature
`ifdef EXPR_SUB_EN
    do_clr();
    send_str("9-2*3");
    check("t6_sub", 32'(value16), 32'h0003);
    do_clr();
    send_str("1-5");
    check("t6_neg", 32'(value16), 32'h0000FFFC);
`else
    do_clr();
    send_str("9-");
    check("t6_minus_illegal", 32'(err16), 32'd1);
`endif

    // Randomized stream against the model
    do_clr();
    for (int n = 0; n < 3000; n++) begin
      int          r;
      byte unsigned c;
      bit          c_clr, c_vld;
      r = int'($urandom_range(0, 99));
      if (r < 55)      c = 8'd48 + 8'($urandom_range(0, 9));
      else if (r < 88) c = opsl[$urandom_range(0, 2)];
      else             c = junk[$urandom_range(0, 4)];
      c_clr = ($urandom_range(0, 99) < 4);
      c_vld = ($urandom_range(0, 99) < 80);
      step(c_clr, c_vld, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
